bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential packed-BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from any BCD digit ≥ 8. It is the return path for the calculator. Keypad and display values held as BCD digits are turned back into binary operands for the ALU. It pairs with the existing binary-to-BCD processor and uses the same start/done handshake.

## Interface
- DIGITS, 4: number of packed BCD digits; word width W = 4*DIGITS.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- data_in  input  W  packed BCD; digit 0 is bits [3:0].
- data_out  output  W  binary result, zero-extended; holds until the next completion.
- done  output  1  one-cycle pulse when data_out/err are updated.
- busy  output  1  high from the cycle after start is accepted until done.
- err  output  1  invalid-digit flag, valid with done; tied 0 when checking is compiled out.

## Operation
- Internal state:
  - register {bcd[W-1:0], bin[W-1:0]};
  - counter cnt, width clog2(W)+1.
- FSM states IDLE, SHIFT, CORR, DONE.
- IDLE:
  - on start=1: bcd←data_in, bin←0, cnt←0, go to SHIFT;
  - otherwise stay.
- SHIFT:
  - {bcd,bin} ← {bcd,bin} >> 1; cnt←cnt+1;
  - if cnt == W-1 (last shift), go to DONE; else go to CORR.
- CORR: for each BCD digit d, if d ≥ 8 then d ← d-3 (4-bit, no borry across digits). Then go to SHIFT.
- DONE: data_out←bin, err←0, done←1, go to IDLE.
- Inputs of all 9s convert without overflow: max 10^DIGITS-1 < 2^W.
- start is ignored in SHIFT, CORR and DONE; there is no queueing.
- A start in the IDLE cycle right after DONE is accepted, so back-to-back operation is possible.
- data_in is sampled only on the accepting edge; later changes have no effect.
- Reset at any time, including mid-conversion:
  - state→IDLE;
  - data_out, done, busy, err, cnt and the shift register all →0;
  - no done pulse for the aborted conversion.

## Timing
- Reset values: data_out=0, done=0, busy=0, err=0.
- Edge E0 samples start=1 in IDLE.
- Edges E1..E(8*DIGITS-1) alternate SHIFT/CORR: W shifts and W-1 corrections.
- Edge E(8*DIGITS) executes DONE.
- done=1 and the new data_out are visible for exactly the one cycle after E(8*DIGITS). For DIGITS=4 that is 32 cycles after the start edge.
- busy is 1 after E0 and falls together with done, so busy=0 while done=1.
- Throughput: one conversion every 8*DIGITS+1 cycles if start is held high.

## Configuration
- BCD_BIN_CHECK_EN defined:
  - at the accepting edge, any data_in digit > 9 sends the FSM directly to DONE;
  - DONE then drives data_out←0 and err←1; done is visible after E1 (latency 1);
  - valid inputs behave exactly as above, with err=0.
- BCD_BIN_CHECK_EN undefined:
  - no digit check; invalid digits are converted by the same algorithm, giving an unspecified binary result;
  - err stays 0.

## Structure
- Shared package bcd_pkg holds:
  - the FSM state encodings (IDLE, SHIFT, CORR, DONE as 2-bit localparams);
  - the DIGITS default;
  - constant CORR_THRESH=8 and CORR_SUB=3.
- One sub-module, bcd_digit_corr: combinational 4-bit in / 4-bit out, computing d≥8 ? d-3 : d. Instantiate it DIGITS times in a generate loop.
- Control and datapath stay in one module, since the FSM is small.

## Test plan
- Reset, then data_in=16'h1234 with a one-cycle start → busy high; done at cycle 32; data_out=16'h04D2; err=0.
- data_in=16'h9999 → data_out=16'h270F; data_in=16'h0000 → data_out=16'h0000, done still at cycle 32.
- Start pulsed again at cycles 5 and 20 of a conversion of 16'h0042 → ignored; a single done with data_out=16'h002A.
- Assert reset at cycle 10 of a conversion of 16'h5678 → all outputs 0 immediately; no done; a following conversion of 16'h0007 → 16'h0007.
- With BCD_BIN_CHECK_EN, data_in=16'h12A4 → done one cycle after the start edge, err=1, data_out=0. Without the macro → done at cycle 32, err=0.
- start held high continuously with data_in=16'h0100 → done every 33 cycles, each with data_out=16'h0064.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants for the packed-BCD to binary converter (optional check: BCD_BIN_CHECK_EN)
package bcd_pkg;

    localparam int DIGITS_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CORR  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_corr.sv
// rtl/bcd_digit_corr.sv - single-digit correction for reverse double dabble (d>=8 ? d-3 : d)
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= CORR_THRESH) ? (d_in - CORR_SUB) : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter; BCD_BIN_CHECK_EN enables invalid-digit rejection
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic [4*DIGITS-1:0]   data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W) + 1;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  bcd_q, bcd_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_out_q, data_out_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          bad_q, bad_d;
    logic [W-1:0]  bcd_corr;
    logic          in_bad;

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        bcd_digit_corr u_corr (
            .d_in  (bcd_q[4*i +: 4]),
            .d_out (bcd_corr[4*i +: 4])
        );
    end

`ifdef BCD_BIN_CHECK_EN
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (data_in[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end
`else
    assign in_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = in_bad ? ST_DONE : ST_SHIFT;
            ST_SHIFT: state_d = (cnt_q == CW'(W - 1)) ? ST_DONE : ST_CORR;
            ST_CORR:  state_d = ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A rejected input leaves bin at zero, so DONE copies bin unconditionally.
    always_comb begin
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        err_d      = err_q;
        bad_d      = bad_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bcd_d  = data_in;
                    bin_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    bad_d  = in_bad;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
                cnt_d          = cnt_q + CW'(1);
            end
            ST_CORR: begin
                bcd_d = bcd_corr;
            end
            default: begin
                data_out_d = bin_q;
                err_d      = bad_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            bad_q      <= bad_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin (DIGITS=4), aware of BCD_BIN_CHECK_EN
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
    logic        err;

    int total;
    int bad;

    bcd_to_bin #(.DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_value(input logic [15:0] bcd);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            v = v * 10 + int'(bcd[4*i +: 4]);
        end
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One conversion driven with a one-cycle start; optional extra start pulses mid-flight.
    task automatic run_conv(input string tag, input logic [15:0] din, input int exp_lat,
                            input logic [15:0] exp_out, input logic exp_err, input bit poke);
        int lat;
        int extra;
        @(negedge clk);
        start   = 1'b1;
        data_in = din;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'($urandom);
        lat     = 0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start   = poke && (lat == 5 || lat == 20);
            data_in = 16'($urandom);
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data_out"}, 32'(data_out), 32'(exp_out));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
        check({tag, "_data_out_held"}, 32'(data_out), 32'(exp_out));
    endtask

    initial begin
        logic [15:0] r;
        int lat;
        int extra;
        int exp_lat_bad;
        logic [15:0] exp_out_bad;
        logic exp_err_bad;

        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b0;

        run_conv("h1234", 16'h1234, 32, 16'h04D2, 1'b0, 1'b0);
        run_conv("h9999", 16'h9999, 32, 16'h270F, 1'b0, 1'b0);
        run_conv("h0000", 16'h0000, 32, 16'h0000, 1'b0, 1'b0);
        run_conv("h0042_poked", 16'h0042, 32, 16'h002A, 1'b0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
            run_conv("random", r, 32, ref_value(r), 1'b0, 1'b0);
        end

        // Abort a conversion with reset at cycle 10.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_data_out", 32'(data_out), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        run_conv("h0007", 16'h0007, 32, 16'h0007, 1'b0, 1'b0);

`ifdef BCD_BIN_CHECK_EN
        exp_lat_bad = 1;
        exp_out_bad = 16'h0000;
        exp_err_bad = 1'b1;
`else
        exp_lat_bad = 32;
        exp_out_bad = data_out;
        exp_err_bad = 1'b0;
`endif
        if (exp_lat_bad == 1) begin
            run_conv("h12A4", 16'h12A4, exp_lat_bad, exp_out_bad, exp_err_bad, 1'b0);
        end else begin
            @(negedge clk);
            start   = 1'b1;
            data_in = 16'h12A4;
            @(negedge clk);
            start = 1'b0;
            lat   = 0;
            while (!done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check("h12A4_latency", 32'(lat), 32'(exp_lat_bad));
            check("h12A4_err", 32'(err), 32'(exp_err_bad));
            repeat (3) @(negedge clk);
        end
        run_conv("after_bad", 16'h0815, 32, 16'd815, 1'b0, 1'b0);

        // start held high: one completion every 33 cycles.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'h0100;
        @(negedge clk);
        lat = 0;
        for (int n = 0; n < 3; n++) begin
            while (!done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            if (n == 2) start = 1'b0;
            check("held_interval", 32'(lat), (n == 0) ? 32'd32 : 32'd33);
            check("held_data_out", 32'(data_out), 32'h0064);
            @(negedge clk);
            lat = 1;
        end
        repeat (40) @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
